regfile_mp: RTL

Parametrised successor to the LC-3 8x16 register file. Provides a NREGS x WIDTH array with two combinational read ports and one write port, plus three capabilities the old file lacks:
- optional write-to-read bypass;
- a per-register pending scoreboard for the pipelined datapath;
- a sequenced clear engine that zeroes the file one register per cycle.

It sits between the decode/issue stage, which reserves destinations, and the writeback bus.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_sb.sv | 58 +++++
 rtl/regfile_mp.sv | 136 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the multi-port register file.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package regfile_pkg;

  // Clear-engine states: IDLE waits for CLR_REQ, SWEEP zeroes one register per cycle.
  typedef enum logic {IDLE, SWEEP} clr_state_t;

  // Defaults shared with the LC-3 datapath.
  localparam int RF_WIDTH = 16;
  localparam int RF_NREGS = 8;

endpackage

// File: rtl/regfile_sb.sv
// Pending scoreboard: one bit per register, set on reserve, cleared on writeback or sweep.
// Latency: set/clear visible on lookups the cycle after the edge; lookups are combinational.
// Backpressure: none; callers gate set/clr while a sweep is running.
//
// Ports: Clk, Reset_n (async active-low); set/set_idx reserve a register;
// clr/clr_idx retire it on writeback; swp/swp_idx clear during sweep;
// lk1_idx/lk2_idx look up pend1/pend2. Out-of-range indices never match.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int NREGS = RF_NREGS,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          set,
  input  logic [AW-1:0] set_idx,
  input  logic          clr,
  input  logic [AW-1:0] clr_idx,
  input  logic          swp,
  input  logic [AW-1:0] swp_idx,
  input  logic [AW-1:0] lk1_idx,
  input  logic [AW-1:0] lk2_idx,
  output logic          pend1,
  output logic          pend2
);

  logic [NREGS-1:0] pend;

  // Set has priority over clear on the same index: a reserve issued in the
  // same cycle as a writeback names a newer producer.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (swp && swp_idx == AW'(i)) begin
          pend[i] <= 1'b0;
        end else if (set && set_idx == AW'(i)) begin
          pend[i] <= 1'b1;
        end else if (clr && clr_idx == AW'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Out-of-range lookups fall through to 0 (not pending).
  always_comb begin
    pend1 = 1'b0;
    pend2 = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (lk1_idx == AW'(i)) pend1 = pend[i];
      if (lk2_idx == AW'(i)) pend2 = pend[i];
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// NREGS x WIDTH register file: 2 combinational reads, 1 write, optional bypass, pending scoreboard, clear sweep.
// Latency: reads 0 cycles; writes visible next cycle (same cycle via bypass); sweep takes NREGS cycles.
// Backpressure: none internally; LD_REG/RSV are dropped while CLR_BUSY is high, upstream must hold off.
//
// Ports: Clk, Reset_n (async active-low); LD_REG/DR/BUS write port;
// SR1/SR2 -> SR1OUT/SR2OUT read ports with SR1_RDY/SR2_RDY source-ready flags;
// RSV/RSV_DR reserve a destination; CLR_REQ starts a sweep, CLR_BUSY while it runs.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter  int WIDTH  = RF_WIDTH,
  parameter  int NREGS  = RF_NREGS,
  parameter  int BYPASS = 1,
  localparam int AW     = $clog2(NREGS)
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             LD_REG,
  input  logic [AW-1:0]    DR,
  input  logic [WIDTH-1:0] BUS,
  input  logic [AW-1:0]    SR1,
  input  logic [AW-1:0]    SR2,
  output logic [WIDTH-1:0] SR1OUT,
  output logic [WIDTH-1:0] SR2OUT,
  output logic             SR1_RDY,
  output logic             SR2_RDY,
  input  logic             RSV,
  input  logic [AW-1:0]    RSV_DR,
  input  logic             CLR_REQ,
  output logic             CLR_BUSY
);

  localparam logic [AW:0]   NREGS_X = (AW + 1)'(NREGS);
  localparam logic [AW-1:0] LAST    = AW'(NREGS - 1);
  localparam bit            BYP     = (BYPASS != 0);

  clr_state_t       state, state_nxt;
  logic [AW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd1, rd2;
  logic             wr_en, rsv_en, byp1, byp2, pend1, pend2;

  assign CLR_BUSY = (state == SWEEP);

  // DR range check only matters for bypass; the array and scoreboard
  // already ignore indices that match no register.
  assign wr_en  = LD_REG && !CLR_BUSY && ({1'b0, DR} < NREGS_X);
  assign rsv_en = RSV && !CLR_BUSY;

  // Reset_n gates bypass so outputs read 0 for the whole reset interval.
  assign byp1 = BYP && Reset_n && wr_en && (DR == SR1);
  assign byp2 = BYP && Reset_n && wr_en && (DR == SR2);

  // Clear engine state register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Clear engine next state. CLR_REQ is only looked at in IDLE, so a request
  // during a sweep is dropped and a held request re-arms after return to IDLE.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (CLR_REQ) begin
          state_nxt = SWEEP;
          cnt_nxt   = '0;
        end
      end
      SWEEP: begin
        if (cnt == LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
    endcase
  end

  // Register array: the sweep slot takes priority, though writes are already
  // gated off while sweeping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (CLR_BUSY && cnt == AW'(i)) begin
          regs[i] <= '0;
        end else if (wr_en && DR == AW'(i)) begin
          regs[i] <= BUS;
        end
      end
    end
  end

  // Read muxes; an index matching no register reads 0.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (SR1 == AW'(i)) rd1 = regs[i];
      if (SR2 == AW'(i)) rd2 = regs[i];
    end
  end

  assign SR1OUT  = byp1 ? BUS : rd1;
  assign SR2OUT  = byp2 ? BUS : rd2;
  assign SR1_RDY = !pend1 || byp1;
  assign SR2_RDY = !pend2 || byp2;

  regfile_sb #(
    .NREGS (NREGS)
  ) u_sb (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .set     (rsv_en),
    .set_idx (RSV_DR),
    .clr     (wr_en),
    .clr_idx (DR),
    .swp     (CLR_BUSY),
    .swp_idx (cnt),
    .lk1_idx (SR1),
    .lk2_idx (SR2),
    .pend1   (pend1),
    .pend2   (pend2)
  );

endmodule
